alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
Byte-stream command sequencer for the 8-bit ALU datapath. It accepts opcode/operand bytes over a valid/ready input channel and sequences operand capture. It runs the operation: single-cycle for logic, arithmetic and shift ops, 8-cycle shift-add for multiply. It returns the result and flags over a valid/ready output channel, and keeps an accumulator so successive commands can chain on the previous result.

Parameters:
WIDTH, 8, data/operand/result width in bits; MUL iteration count equals WIDTH.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  command byte valid
in_ready  out  1  block can accept a command byte
in_data  in  WIDTH  opcode byte, or operand A, or operand B
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  WIDTH  result
res_flags  out  3  {V,Z,C}
busy  out  1  state != IDLE

Behaviour:
- Interface: one clock `clk`; `rst` is asynchronous and active-high.
- Reset values: state=IDLE, acc=0, res_data=0, res_flags=0, res_valid=0, busy=0. in_ready=1 as soon as rst deasserts.
- Handshake: a transfer occurs on a rising edge where valid&ready=1. in_ready=1 only in IDLE, GET_A and GET_B. res_valid=1 only in OUT.
- While res_valid=1 and res_ready=0, res_data and res_flags hold stable.
- Opcode byte:
  - [2:0] op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
  - [3] use_acc: A=acc, and the GET_A state is skipped.
  - [7:4] reserved, ignored.
- States:
  - IDLE: opcode accepted -> GET_A, or -> GET_B if use_acc.
  - GET_A: byte accepted -> A, -> GET_B.
  - GET_B: byte accepted -> B, -> EXEC, or -> MUL if op=7.
  - EXEC: one cycle; combinational result registered -> OUT.
  - MUL: exactly WIDTH cycles of shift-add, 2*WIDTH-bit product -> OUT.
  - OUT: on res_ready -> IDLE.
- Latency, with the B handshake in cycle N:
  - ops 0-6: EXEC in N+1, res_valid from N+2.
  - MUL: MUL in N+1..N+8, res_valid from N+9.
  - Earliest next opcode accept is the cycle after the result handshake.
- Arithmetic, all modulo 2^WIDTH:
  - ADD: C=carry out; V=signed overflow.
  - SUB: A-B; C=borrow (A<B unsigned); V=signed overflow.
  - AND/OR/XOR: C=0, V=0.
  - SHL/SHR: shift amount B[2:0], logical, zero fill. C=last bit shifted out, or 0 when the amount is 0. V=0.
  - MUL: unsigned. res_data=low WIDTH bits; C=|high WIDTH bits; V=0.
  - Z=(res_data==0) for all ops.
- Accumulator: acc loads res_data on entry to OUT, not on the result handshake.
- Boundary conditions:
  - in_valid while in_ready=0: ignored, no capture; the byte must be held by the source.
  - res_ready asserted outside OUT: no effect.
  - rst asserted mid-command, including mid-MUL: immediate return to reset values, partial operands discarded, no res_valid pulse.
  - use_acc immediately after reset: acc=0.

Decomposition:
- Package alu_seq_pkg holds:
  - op_e opcode enum (ADD..MUL);
  - state_e enum (IDLE, GET_A, GET_B, EXEC, MUL, OUT);
  - flag bit indices FLAG_C=0, FLAG_Z=1, FLAG_V=2;
  - opcode field positions OPC_OP_LSB/MSB and OPC_USE_ACC=3.
- Sub-module alu_comb: purely combinational ops 0-6, WIDTH-parameterised, outputs result and {V,C}.
- The MUL shift-add engine and the FSM stay in alu_seq_ctrl.

Test Plan:
- ADD: opcode 0x00, A=200, B=100 -> res_data=44, C=1, Z=0, V=0; res_valid two cycles after the B handshake. Then ADD 127+1 -> 128, V=1, C=0.
- SUB: opcode 0x01, A=5, B=7 -> 254, C=1, V=0. Then SUB 9-9 -> 0, Z=1, C=0.
- MUL: opcode 0x07, A=13, B=21 -> res_data=0x11, C=1; res_valid exactly 9 cycles after the B handshake; busy=1 throughout. Then MUL 15*17 -> 255, C=0.
- Chaining: ADD 40+4=44 accepted, then opcode 0x08 (ADD, use_acc) with only B=6 sent -> 50; exactly two input bytes accepted for the second command.
- Backpressure: res_ready held low 5 cycles -> res_valid stays 1, res_data/res_flags stable, in_ready=0. A new opcode offered meanwhile is not captured until after the result is accepted.
- Reset mid-op: assert rst in the 4th MUL cycle -> same-cycle res_valid=0, busy=0, acc=0. Next command SHL A=0x81, B=1 -> 0x02, C=1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and field positions for the ALU command sequencer.
// Opcode, FSM state, flag indices and opcode byte layout.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_SHL,
    OP_SHR,
    OP_MUL
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_MUL,
    S_OUT
  } state_e;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;

  localparam int OPC_OP_LSB  = 0;
  localparam int OPC_OP_MSB  = 2;
  localparam int OPC_USE_ACC = 3;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU ops (add/sub/logic/shift).
// Produces the result plus overflow and carry/borrow.
module alu_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y,
  output logic             o_v,
  output logic             o_c
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   w_wide;
  logic [WIDTH-1:0] w_y;
  logic             w_v;
  logic             w_c;
  logic [2:0]       w_sh;

  assign w_sh = i_b[2:0];

  // Select the operation; the extra wide bit carries C out of add/sub/shift.
  always_comb begin
    w_wide = '0;
    w_y    = '0;
    w_v    = 1'b0;
    w_c    = 1'b0;
    unique case (i_op)
      OP_ADD: begin
        w_wide = {1'b0, i_a} + {1'b0, i_b};
        w_y    = w_wide[WIDTH-1:0];
        w_c    = w_wide[WIDTH];
        w_v    = (i_a[MSB] == i_b[MSB]) &&
                 (w_y[MSB] != i_a[MSB]);
      end
      OP_SUB: begin
        w_wide = {1'b0, i_a} - {1'b0, i_b};
        w_y    = w_wide[WIDTH-1:0];
        w_c    = w_wide[WIDTH];
        w_v    = (i_a[MSB] != i_b[MSB]) &&
                 (w_y[MSB] != i_a[MSB]);
      end
      OP_AND: w_y = i_a & i_b;
      OP_OR:  w_y = i_a | i_b;
      OP_XOR: w_y = i_a ^ i_b;
      OP_SHL: begin
        w_wide = {1'b0, i_a} << w_sh;
        w_y    = w_wide[WIDTH-1:0];
        w_c    = w_wide[WIDTH];
      end
      OP_SHR: begin
        w_wide = {i_a, 1'b0} >> w_sh;
        w_y    = w_wide[WIDTH:1];
        w_c    = w_wide[0];
      end
      default: begin
        w_y = '0;
      end
    endcase
  end

  assign o_y = w_y;
  assign o_v = w_v;
  assign o_c = w_c;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Byte-stream command sequencer for the 8-bit ALU datapath.
// Collects opcode/operands, runs ALU or shift-add MUL, returns result.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [2:0]       res_flags,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e             r_state;
  op_e                r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_res;
  logic [2:0]         r_flags;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_prod;

  logic [WIDTH-1:0]   w_y;
  logic               w_v;
  logic               w_c;
  logic [2:0]         w_flags;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_step;
  logic [2:0]         w_mflags;

  alu_comb #(.WIDTH(WIDTH)) u_alu (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_y  (w_y),
    .o_v  (w_v),
    .o_c  (w_c)
  );

  // Pack ALU flags and form one shift-add step of the multiplier.
  always_comb begin
    w_flags         = '0;
    w_flags[FLAG_V] = w_v;
    w_flags[FLAG_Z] = (w_y == '0);
    w_flags[FLAG_C] = w_c;
    w_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
           + (r_prod[0] ? {1'b0, r_a} : '0);
    w_step = {w_sum, r_prod[WIDTH-1:1]};
    w_mflags         = '0;
    w_mflags[FLAG_Z] = (w_step[WIDTH-1:0] == '0);
    w_mflags[FLAG_C] = |w_step[2*WIDTH-1:WIDTH];
  end

  // Command FSM with operand capture, MUL iteration and result hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_res   <= '0;
      r_flags <= '0;
      r_cnt   <= '0;
      r_prod  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op <= op_e'(in_data[OPC_OP_MSB:OPC_OP_LSB]);
            if (in_data[OPC_USE_ACC]) begin
              r_a     <= r_acc;
              r_state <= S_GET_B;
            end else begin
              r_state <= S_GET_A;
            end
          end
        end
        S_GET_A: begin
          if (in_valid) begin
            r_a     <= in_data;
            r_state <= S_GET_B;
          end
        end
        S_GET_B: begin
          if (in_valid) begin
            r_b     <= in_data;
            r_prod  <= {{WIDTH{1'b0}}, in_data};
            r_cnt   <= '0;
            r_state <= (r_op == OP_MUL) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          r_res   <= w_y;
          r_flags <= w_flags;
          r_acc   <= w_y;
          r_state <= S_OUT;
        end
        S_MUL: begin
          r_prod <= w_step;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_res   <= w_step[WIDTH-1:0];
            r_flags <= w_mflags;
            r_acc   <= w_step[WIDTH-1:0];
            r_state <= S_OUT;
          end
        end
        S_OUT: begin
          if (res_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) ||
                     (r_state == S_GET_A) ||
                     (r_state == S_GET_B);
  assign res_valid = (r_state == S_OUT);
  assign busy      = (r_state != S_IDLE);
  assign res_data  = r_res;
  assign res_flags = r_flags;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl.
// Directed scenarios plus randomized commands against a reference model.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [2:0] res_flags;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;
  int n_hs    = 0;
  logic [7:0] m_acc;

  alu_seq_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_flags (res_flags),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (in_valid && in_ready) n_hs <= n_hs + 1;
  end

  // Reference: returns {V,Z,C,result} from plain integer arithmetic.
  function automatic logic [10:0] model(input logic [7:0] opc,
                                        input int a, input int b);
    int r, c, v, n, sa, sb;
    logic [7:0] r8;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    n = b % 8;
    c = 0;
    v = 0;
    case (opc[2:0])
      3'd0: begin
        r = a + b; c = (r > 255);
        v = (sa + sb > 127) || (sa + sb < -128);
      end
      3'd1: begin
        r = a - b; c = (a < b);
        v = (sa - sb > 127) || (sa - sb < -128);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        r = a << n;
        c = (n != 0) ? ((r >> 8) & 1) : 0;
      end
      3'd6: begin
        r = a >> n;
        c = (n != 0) ? ((a >> (n - 1)) & 1) : 0;
      end
      default: begin
        r = a * b; c = (r > 255);
      end
    endcase
    r8 = r[7:0];
    return {v[0], (r8 == 8'd0), c[0], r8};
  endfunction

  task automatic send_byte(input logic [7:0] d);
    int k = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [7:0] opc, input logic [7:0] a,
                         input logic [7:0] b, input int hold,
                         output logic [7:0] res, output logic [2:0] fl,
                         output int lat);
    send_byte(opc);
    if (!opc[3]) send_byte(a);
    send_byte(b);
    lat = 0;
    while (!res_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    res = res_data;
    fl  = res_flags;
    repeat (hold) @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    n_total++;
    if ({res_valid, busy} !== 2'b00) $display("FAIL rst_vb: got %b want 00", {res_valid, busy});
    else n_pass++;
    n_total++;
    if (res_data !== 8'd0) $display("FAIL rst_data: got %0h want 0", res_data);
    else n_pass++;
    n_total++;
    if (res_flags !== 3'd0) $display("FAIL rst_flags: got %0h want 0", res_flags);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_add;
    logic [7:0] r; logic [2:0] f; int lat;
    run_cmd(8'h00, 8'd200, 8'd100, 0, r, f, lat);
    n_total++;
    if (r !== 8'd44) $display("FAIL add1_data: got %0d want 44", r);
    else n_pass++;
    n_total++;
    if (f !== 3'b001) $display("FAIL add1_flags: got %b want 001", f);
    else n_pass++;
    n_total++;
    if (lat !== 1) $display("FAIL add1_latency: got %0d want 1", lat);
    else n_pass++;
    run_cmd(8'h00, 8'd127, 8'd1, 0, r, f, lat);
    n_total++;
    if ({f, r} !== {3'b100, 8'd128}) $display("FAIL add2: got %b/%0d want 100/128", f, r);
    else n_pass++;
  endtask

  task automatic test_sub;
    logic [7:0] r; logic [2:0] f; int lat;
    run_cmd(8'h01, 8'd5, 8'd7, 0, r, f, lat);
    n_total++;
    if ({f, r} !== {3'b001, 8'd254}) $display("FAIL sub1: got %b/%0d want 001/254", f, r);
    else n_pass++;
    run_cmd(8'h01, 8'd9, 8'd9, 0, r, f, lat);
    n_total++;
    if ({f, r} !== {3'b010, 8'd0}) $display("FAIL sub2: got %b/%0d want 010/0", f, r);
    else n_pass++;
  endtask

  task automatic test_mul;
    logic [7:0] r; logic [2:0] f; int lat; bit busy_ok;
    send_byte(8'h07);
    send_byte(8'd13);
    send_byte(8'd21);
    lat = 0;
    busy_ok = 1'b1;
    while (!res_valid && lat < 50) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    n_total++;
    if (lat !== 8) $display("FAIL mul_latency: got %0d want 8", lat);
    else n_pass++;
    n_total++;
    if (busy_ok !== 1'b1) $display("FAIL mul_busy: got %b want 1", busy_ok);
    else n_pass++;
    n_total++;
    if ({res_flags, res_data} !== {3'b001, 8'h11})
      $display("FAIL mul1: got %b/%0h want 001/11", res_flags, res_data);
    else n_pass++;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    run_cmd(8'h07, 8'd15, 8'd17, 0, r, f, lat);
    n_total++;
    if ({f, r} !== {3'b000, 8'd255}) $display("FAIL mul2: got %b/%0d want 000/255", f, r);
    else n_pass++;
  endtask

  task automatic test_chain;
    logic [7:0] r; logic [2:0] f; int lat; int hs0;
    run_cmd(8'h00, 8'd40, 8'd4, 0, r, f, lat);
    n_total++;
    if (r !== 8'd44) $display("FAIL chain1: got %0d want 44", r);
    else n_pass++;
    hs0 = n_hs;
    run_cmd(8'h08, 8'd0, 8'd6, 0, r, f, lat);
    n_total++;
    if (r !== 8'd50) $display("FAIL chain2: got %0d want 50", r);
    else n_pass++;
    n_total++;
    if (n_hs - hs0 !== 2) $display("FAIL chain_bytes: got %0d want 2", n_hs - hs0);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    int lat; bit ok; logic [7:0] r0; logic [2:0] f0;
    logic [7:0] r; logic [2:0] f;
    send_byte(8'h04);
    send_byte(8'hF0);
    send_byte(8'h3C);
    lat = 0;
    while (!res_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    r0 = res_data;
    f0 = res_flags;
    n_total++;
    if ({f0, r0} !== {3'b000, 8'hCC}) $display("FAIL bp_result: got %b/%0h want 000/cc", f0, r0);
    else n_pass++;
    in_valid = 1'b1;
    in_data  = 8'h02;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b1 || in_ready !== 1'b0 ||
          res_data !== r0 || res_flags !== f0) ok = 1'b0;
    end
    n_total++;
    if (ok !== 1'b1) $display("FAIL bp_hold: got %b want 1", ok);
    else n_pass++;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    n_total++;
    if ({busy, in_ready} !== 2'b01) $display("FAIL bp_no_capture: got %b want 01", {busy, in_ready});
    else n_pass++;
    send_byte(8'h02);
    send_byte(8'hF0);
    send_byte(8'h3C);
    lat = 0;
    while (!res_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    r = res_data;
    f = res_flags;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    n_total++;
    if ({f, r} !== {3'b000, 8'h30}) $display("FAIL bp_next: got %b/%0h want 000/30", f, r);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mul;
    logic [7:0] r; logic [2:0] f; int lat;
    send_byte(8'h07);
    send_byte(8'd99);
    send_byte(8'd77);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_total++;
    if ({res_valid, busy} !== 2'b00) $display("FAIL midrst_vb: got %b want 00", {res_valid, busy});
    else n_pass++;
    n_total++;
    if ({res_flags, res_data} !== 11'd0) $display("FAIL midrst_out: got %0h want 0", {res_flags, res_data});
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    run_cmd(8'h08, 8'd0, 8'd5, 0, r, f, lat);
    n_total++;
    if (r !== 8'd5) $display("FAIL midrst_acc: got %0d want 5", r);
    else n_pass++;
    run_cmd(8'h05, 8'h81, 8'd1, 0, r, f, lat);
    n_total++;
    if ({f, r} !== {3'b001, 8'h02}) $display("FAIL midrst_shl: got %b/%0h want 001/02", f, r);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [7:0] opc, a, b, ea, r; logic [2:0] f; logic [10:0] e;
    int lat, elat;
    for (int i = 0; i < 40; i++) begin
      opc = 8'($urandom);
      if (i == 0) opc[3] = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      ea = opc[3] ? m_acc : a;
      e = model(opc, int'(ea), int'(b));
      elat = (opc[2:0] == 3'd7) ? 8 : 1;
      run_cmd(opc, a, b, int'($urandom_range(0, 2)), r, f, lat);
      m_acc = e[7:0];
      n_total++;
      if (r !== e[7:0]) $display("FAIL rnd_data[%0d] op=%0h: got %0h want %0h", i, opc, r, e[7:0]);
      else n_pass++;
      n_total++;
      if (f !== e[10:8]) $display("FAIL rnd_flags[%0d] op=%0h: got %b want %b", i, opc, f, e[10:8]);
      else n_pass++;
      n_total++;
      if (lat !== elat) $display("FAIL rnd_lat[%0d] op=%0h: got %0d want %0d", i, opc, lat, elat);
      else n_pass++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    res_ready = 1'b0;
    m_acc     = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_chain();
    test_backpressure();
    test_reset_mid_mul();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
